// File: rtl/qed_inst_issuer_if.sv
// Host-load and core-issue signal bundle for qed_inst_issuer.
// slave = the issuer; master = the host plus the core (or a testbench standing in for both).
interface qed_inst_issuer_if #(
  parameter int unsigned DEPTH = 16
);
  localparam int unsigned LEN_W = $clog2(DEPTH) + 1;

  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic             in_last;
  logic             pipeline_stall;
  logic [31:0]      instruction;
  logic             qed_exec_dup;
  logic             issue_valid;
  logic [LEN_W-1:0] batch_len;
  logic             batch_done;

  modport master (
    output in_valid, in_instr, in_last, pipeline_stall,
    input  in_ready, instruction, qed_exec_dup, issue_valid, batch_len, batch_done
  );

  modport slave (
    input  in_valid, in_instr, in_last, pipeline_stall,
    output in_ready, instruction, qed_exec_dup, issue_valid, batch_len, batch_done
  );
endinterface

// File: rtl/qed_inst_issuer.sv
// Loads a batch of original instructions, issues it as originals and then as duplicates, and pads with NOPs.
// Define QED_ISSUE_INTERLEAVE_EN to alternate original/duplicate copies per entry instead of issuing whole passes.
module qed_inst_issuer #(
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned DRAIN_CYCLES = 5,
  parameter logic [31:0] NOP_INSTR    = 32'h00000013
) (
  input logic              clk,
  input logic              reset,
  qed_inst_issuer_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LEN_W = PTR_W + 1;
  localparam int unsigned CNT_W = $clog2(DRAIN_CYCLES) + 1;

  localparam logic [1:0] ST_LOAD  = 2'd0;
`ifdef QED_ISSUE_INTERLEAVE_EN
  localparam logic [1:0] ST_ISSUE = 2'd1;
`else
  localparam logic [1:0] ST_ORIG  = 2'd1;
  localparam logic [1:0] ST_DUP   = 2'd2;
`endif
  localparam logic [1:0] ST_DRAIN = 2'd3;

  logic [1:0]       r_state,     w_state_nxt;
  logic [PTR_W-1:0] r_wr_ptr,    w_wr_ptr_nxt;
  logic [PTR_W-1:0] r_rd_idx,    w_rd_idx_nxt;
  logic [LEN_W-1:0] r_batch_len, w_batch_len_nxt;
  logic [CNT_W-1:0] r_drain_cnt, w_drain_cnt_nxt;
  logic [31:0]      r_buf [DEPTH];
`ifdef QED_ISSUE_INTERLEAVE_EN
  logic             r_phase,     w_phase_nxt;
`endif

  logic w_xfer;
  logic w_consume;
  logic w_last_rd;
  logic w_last_drain;
  logic w_issuing;

  assign w_xfer       = bus.in_valid && (r_state == ST_LOAD);
  assign w_consume    = (r_state != ST_LOAD) && !bus.pipeline_stall;
  assign w_last_rd    = (LEN_W'(r_rd_idx) == (r_batch_len - LEN_W'(1)));
  assign w_last_drain = (r_drain_cnt == CNT_W'(DRAIN_CYCLES - 1));

  // Next-state and counter updates; every register holds unless its state consumes or loads.
  always_comb begin
    w_state_nxt     = r_state;
    w_wr_ptr_nxt    = r_wr_ptr;
    w_rd_idx_nxt    = r_rd_idx;
    w_batch_len_nxt = r_batch_len;
    w_drain_cnt_nxt = r_drain_cnt;
`ifdef QED_ISSUE_INTERLEAVE_EN
    w_phase_nxt     = r_phase;
`endif
    case (r_state)
      ST_LOAD: begin
        if (w_xfer) begin
          w_wr_ptr_nxt = r_wr_ptr + PTR_W'(1);
          if (bus.in_last || (r_wr_ptr == PTR_W'(DEPTH - 1))) begin
            w_batch_len_nxt = LEN_W'(r_wr_ptr) + LEN_W'(1);
            w_rd_idx_nxt    = '0;
`ifdef QED_ISSUE_INTERLEAVE_EN
            w_state_nxt     = ST_ISSUE;
            w_phase_nxt     = 1'b0;
`else
            w_state_nxt     = ST_ORIG;
`endif
          end
        end
      end
`ifdef QED_ISSUE_INTERLEAVE_EN
      // Phase 0 presents the original copy, phase 1 the duplicate of the same entry.
      ST_ISSUE: begin
        if (w_consume) begin
          w_phase_nxt = !r_phase;
          if (r_phase) begin
            if (w_last_rd) begin
              w_state_nxt     = ST_DRAIN;
              w_rd_idx_nxt    = '0;
              w_drain_cnt_nxt = '0;
            end else begin
              w_rd_idx_nxt = r_rd_idx + PTR_W'(1);
            end
          end
        end
      end
`else
      ST_ORIG: begin
        if (w_consume) begin
          if (w_last_rd) begin
            w_state_nxt  = ST_DUP;
            w_rd_idx_nxt = '0;
          end else begin
            w_rd_idx_nxt = r_rd_idx + PTR_W'(1);
          end
        end
      end
      ST_DUP: begin
        if (w_consume) begin
          if (w_last_rd) begin
            w_state_nxt     = ST_DRAIN;
            w_rd_idx_nxt    = '0;
            w_drain_cnt_nxt = '0;
          end else begin
            w_rd_idx_nxt = r_rd_idx + PTR_W'(1);
          end
        end
      end
`endif
      ST_DRAIN: begin
        if (w_consume) begin
          if (w_last_drain) begin
            w_state_nxt  = ST_LOAD;
            w_wr_ptr_nxt = '0;
          end else begin
            w_drain_cnt_nxt = r_drain_cnt + CNT_W'(1);
          end
        end
      end
      default: w_state_nxt = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_LOAD;
      r_wr_ptr    <= '0;
      r_rd_idx    <= '0;
      r_batch_len <= '0;
      r_drain_cnt <= '0;
`ifdef QED_ISSUE_INTERLEAVE_EN
      r_phase     <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_wr_ptr    <= w_wr_ptr_nxt;
      r_rd_idx    <= w_rd_idx_nxt;
      r_batch_len <= w_batch_len_nxt;
      r_drain_cnt <= w_drain_cnt_nxt;
`ifdef QED_ISSUE_INTERLEAVE_EN
      r_phase     <= w_phase_nxt;
`endif
    end
  end

  // Batch storage needs no reset; only entries below batch_len are ever read.
  always_ff @(posedge clk) begin
    if (w_xfer) begin
      r_buf[r_wr_ptr] <= bus.in_instr;
    end
  end

`ifdef QED_ISSUE_INTERLEAVE_EN
  assign w_issuing        = (r_state == ST_ISSUE);
  assign bus.qed_exec_dup = w_issuing && r_phase;
`else
  assign w_issuing        = (r_state == ST_ORIG) || (r_state == ST_DUP);
  assign bus.qed_exec_dup = (r_state == ST_DUP);
`endif

  assign bus.in_ready    = (r_state == ST_LOAD);
  assign bus.issue_valid = w_issuing;
  assign bus.instruction = w_issuing ? r_buf[r_rd_idx] : NOP_INSTR;
  assign bus.batch_len   = r_batch_len;
  assign bus.batch_done  = (r_state == ST_DRAIN) && w_consume && w_last_drain;

endmodule

// File: tb/tb_qed_inst_issuer.sv
// Scoreboard bench for qed_inst_issuer: the expected issue stream is queued at load time and popped per consumed word.
module tb_qed_inst_issuer;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned DRAIN = 5;
  localparam logic [31:0] NOP   = 32'h00000013;

  typedef struct packed {
    logic [31:0] w;
    logic        d;
  } exp_t;

  logic clk;
  logic reset;
  qed_inst_issuer_if #(.DEPTH(DEPTH)) ifc ();

  qed_inst_issuer #(.DEPTH(DEPTH), .DRAIN_CYCLES(DRAIN), .NOP_INSTR(NOP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_total = 0;
  int          n_bad   = 0;
  exp_t        sb[$];
  logic [31:0] words[$];
  int          exp_len = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_abc();
    words.delete();
    words.push_back(32'h0000_0A0A);
    words.push_back(32'h0000_0B0B);
    words.push_back(32'h0000_0C0C);
  endtask

  // Expected core-side stream for the batch currently in words.
  task automatic push_exp();
`ifdef QED_ISSUE_INTERLEAVE_EN
    foreach (words[i]) begin
      sb.push_back('{w: words[i], d: 1'b0});
      sb.push_back('{w: words[i], d: 1'b1});
    end
`else
    foreach (words[i]) sb.push_back('{w: words[i], d: 1'b0});
    foreach (words[i]) sb.push_back('{w: words[i], d: 1'b1});
`endif
    exp_len = words.size();
  endtask

  task automatic wait_ready();
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (ifc.in_ready) return;
    end
    chk("ready_timeout", 32'd0, 32'd1);
  endtask

  // Entered and left at posedge+1.
  task automatic load_batch(input bit last);
    for (int i = 0; i < words.size(); i++) begin
      ifc.in_valid = 1'b1;
      ifc.in_instr = words[i];
      ifc.in_last  = last && (i == words.size() - 1);
      wait_ready();
      @(posedge clk); #1;
    end
    ifc.in_valid = 1'b0;
    ifc.in_last  = 1'b0;
    push_exp();
  endtask

  // Runs issue + drain; stalls stall_len cycles at stream position stall_at (issued words then NOPs).
  task automatic run_batch(input int stall_at, input int stall_len);
    int  pos  = 0;
    int  nop  = 0;
    int  hold = 0;
    bit  done = 0;
    bit  stall;
    exp_t e;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      stall = (pos == stall_at) && (hold < stall_len);
      if (stall) hold++;
      ifc.pipeline_stall = stall;
      @(negedge clk);
      chk("in_ready_busy", 32'(ifc.in_ready), 32'd0);
      chk("batch_len", 32'(ifc.batch_len), 32'(exp_len));
      if (sb.size() > 0) begin
        e = sb[0];
        chk("issue_valid", 32'(ifc.issue_valid), 32'd1);
        chk("instr", ifc.instruction, e.w);
        chk("dup", 32'(ifc.qed_exec_dup), 32'(e.d));
        chk("done_early", 32'(ifc.batch_done), 32'd0);
        if (!stall) begin
          void'(sb.pop_front());
          pos++;
        end
      end else begin
        chk("drain_valid", 32'(ifc.issue_valid), 32'd0);
        chk("drain_instr", ifc.instruction, NOP);
        chk("drain_dup", 32'(ifc.qed_exec_dup), 32'd0);
        chk("batch_done", 32'(ifc.batch_done), 32'((!stall) && (nop == DRAIN - 1)));
        if (!stall) begin
          if (nop == DRAIN - 1) done = 1;
          nop++;
          pos++;
        end
      end
      @(posedge clk); #1;
    end
    ifc.pipeline_stall = 1'b0;
    if (!done) chk("drain_timeout", 32'd0, 32'd1);
    @(negedge clk);
    chk("ready_after", 32'(ifc.in_ready), 32'd1);
    chk("done_after", 32'(ifc.batch_done), 32'd0);
    chk("len_held", 32'(ifc.batch_len), 32'(exp_len));
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] x;
    reset              = 1'b1;
    ifc.in_valid       = 1'b0;
    ifc.in_instr       = '0;
    ifc.in_last        = 1'b0;
    ifc.pipeline_stall = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(ifc.in_ready), 32'd1);
    chk("rst_instr", ifc.instruction, NOP);
    chk("rst_dup", 32'(ifc.qed_exec_dup), 32'd0);
    chk("rst_valid", 32'(ifc.issue_valid), 32'd0);
    chk("rst_len", 32'(ifc.batch_len), 32'd0);
    chk("rst_done", 32'(ifc.batch_done), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // A,B,C no stalls
    set_abc();
    load_batch(1'b1);
    run_batch(-1, 0);

    // Two-cycle stall on the second issued word
    load_batch(1'b1);
    run_batch(1, 2);

    // Stall on the final drain cycle delays batch_done
    load_batch(1'b1);
    run_batch(6 + DRAIN - 1, 1);

    // Full buffer; a 17th word waits until LOAD comes back and then forms a single-entry batch
    words.delete();
    for (int i = 0; i < DEPTH; i++) words.push_back($urandom);
    load_batch(1'b0);
    x            = 32'h00500093;
    ifc.in_valid = 1'b1;
    ifc.in_instr = x;
    ifc.in_last  = 1'b1;
    run_batch(-1, 0);
    ifc.in_valid = 1'b0;
    ifc.in_last  = 1'b0;
    words.delete();
    words.push_back(x);
    push_exp();
    run_batch(-1, 0);

    // Reset while the second duplicate-pass entry is presented
    set_abc();
    load_batch(1'b1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("pre_rst_instr", ifc.instruction, sb[0].w);
      void'(sb.pop_front());
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("mid_instr", ifc.instruction, sb[0].w);
    chk("mid_dup", 32'(ifc.qed_exec_dup), 32'(sb[0].d));
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mrst_ready", 32'(ifc.in_ready), 32'd1);
    chk("mrst_instr", ifc.instruction, NOP);
    chk("mrst_dup", 32'(ifc.qed_exec_dup), 32'd0);
    chk("mrst_valid", 32'(ifc.issue_valid), 32'd0);
    chk("mrst_len", 32'(ifc.batch_len), 32'd0);
    chk("mrst_done", 32'(ifc.batch_done), 32'd0);
    reset = 1'b0;
    sb.delete();
    exp_len = 0;
    repeat (3) begin
      @(negedge clk);
      chk("idle_done", 32'(ifc.batch_done), 32'd0);
      chk("idle_ready", 32'(ifc.in_ready), 32'd1);
    end
    @(posedge clk); #1;

    // Two-entry batch after reset
    words.delete();
    words.push_back(32'h0000_0A0A);
    words.push_back(32'h0000_0B0B);
    load_batch(1'b1);
    run_batch(-1, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
